// File: rtl/cache_arbiter.sv
// Two-port round-robin arbiter that sequences one transaction at a time onto
// the single cache access port, with a watchdog for transactions that never complete.
module cache_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   input  logic          req0_rw,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdata,
   output logic          req0_ready,
   output logic          req0_done,
   output logic [DW-1:0] req0_rdata,
   output logic          req0_err,
   input  logic          req1_valid,
   input  logic          req1_rw,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdata,
   output logic          req1_ready,
   output logic          req1_done,
   output logic [DW-1:0] req1_rdata,
   output logic          req1_err,
   output logic          cache_valid,
   output logic          cache_rw,
   output logic [AW-1:0] cache_addr,
   output logic [DW-1:0] cache_wdata,
   input  logic          cache_ready,
   input  logic [DW-1:0] cache_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam bit          WD_EN   = (TIMEOUT != 0);
   localparam logic [15:0] WD_LAST = 16'(WD_EN ? TIMEOUT - 1 : 0);

   state_t        state;
   logic          last_gnt;
   logic          gnt_id;
   logic [15:0]   wd_cnt;
   logic          win;
   logic          accept;
   logic [DW-1:0] cap_data;

   // On a tie the port that was not granted last time wins.
   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      win = 1'b0;
      if (req0_valid && req1_valid) win = ~last_gnt;
      else if (req1_valid)          win = 1'b1;
   end

   // Gated by rst_n so the ready strobes read 0 while reset is held.
   assign accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
   assign req0_ready = accept && !win;
   assign req1_ready = accept && win;
   assign cap_data   = cache_rw ? '0 : cache_rdata;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_gnt    <= 1'b1;
         gnt_id      <= 1'b0;
         wd_cnt      <= '0;
         cache_valid <= 1'b0;
         cache_rw    <= 1'b0;
         cache_addr  <= '0;
         cache_wdata <= '0;
         busy        <= 1'b0;
         req0_done   <= 1'b0;
         req0_rdata  <= '0;
         req0_err    <= 1'b0;
         req1_done   <= 1'b0;
         req1_rdata  <= '0;
         req1_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cache_rw    <= win ? req1_rw    : req0_rw;
                  cache_addr  <= win ? req1_addr  : req0_addr;
                  cache_wdata <= win ? req1_wdata : req0_wdata;
                  gnt_id      <= win;
                  last_gnt    <= win;
                  wd_cnt      <= '0;
                  cache_valid <= 1'b1;
                  busy        <= 1'b1;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               if (cache_ready) begin
                  req0_done   <= !gnt_id;
                  req1_done   <= gnt_id;
                  req0_rdata  <= gnt_id ? '0 : cap_data;
                  req1_rdata  <= gnt_id ? cap_data : '0;
                  req0_err    <= 1'b0;
                  req1_err    <= 1'b0;
                  cache_valid <= 1'b0;
                  state       <= DONE;
               end else if (WD_EN && wd_cnt == WD_LAST) begin
                  req0_done   <= !gnt_id;
                  req1_done   <= gnt_id;
                  req0_rdata  <= '0;
                  req1_rdata  <= '0;
                  req0_err    <= !gnt_id;
                  req1_err    <= gnt_id;
                  cache_valid <= 1'b0;
                  state       <= DONE;
               end else begin
                  wd_cnt <= wd_cnt + 16'd1;
               end
            end
            DONE: begin
               req0_done  <= 1'b0;
               req0_rdata <= '0;
               req0_err   <= 1'b0;
               req1_done  <= 1'b0;
               req1_rdata <= '0;
               req1_err   <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single transfers, round-robin ties,
// watchdog expiry, ready on the last watchdog cycle and reset mid-transfer.
module tb_cache_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_rw, req0_ready, req0_done, req0_err;
   logic [31:0] req0_addr, req0_wdata, req0_rdata;
   logic        req1_valid, req1_rw, req1_ready, req1_done, req1_err;
   logic [31:0] req1_addr, req1_wdata, req1_rdata;
   logic        cache_valid, cache_rw, cache_ready, busy;
   logic [31:0] cache_addr, cache_wdata, cache_rdata;

   int errors = 0;
   int checks = 0;

   cache_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
      .req0_rdata(req0_rdata), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
      .req1_rdata(req1_rdata), .req1_err(req1_err),
      .cache_valid(cache_valid), .cache_rw(cache_rw), .cache_addr(cache_addr),
      .cache_wdata(cache_wdata), .cache_ready(cache_ready),
      .cache_rdata(cache_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: observed=hung expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      rst_n = 1'b0;
      req0_valid = 0; req0_rw = 0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 0; req1_rw = 0; req1_addr = '0; req1_wdata = '0;
      cache_ready = 0; cache_rdata = '0;
      #12;
      check("rst_cache_valid", 32'(cache_valid), 0);
      check("rst_cache_addr",  cache_addr, 0);
      check("rst_cache_wdata", cache_wdata, 0);
      check("rst_busy",        32'(busy), 0);
      check("rst_done",        32'({req0_done, req1_done}), 0);
      rst_n = 1'b1;
      tick();

      // Port 0 write, cache_ready in the 3rd BUSY cycle.
      req0_valid = 1; req0_rw = 1; req0_addr = 32'h8000_0000; req0_wdata = 32'h1234_5678;
      #1;
      check("t1_req0_ready", 32'(req0_ready), 1);
      check("t1_req1_ready", 32'(req1_ready), 0);
      tick();
      req0_valid = 0;
      check("t1_cache_valid", 32'(cache_valid), 1);
      check("t1_cache_rw",    32'(cache_rw), 1);
      check("t1_busy",        32'(busy), 1);
      check("t1_ready_busy",  32'(req0_ready), 0);
      for (int c = 1; c <= 3; c++) begin
         check("t1_addr_hold",  cache_addr, 32'h8000_0000);
         check("t1_wdata_hold", cache_wdata, 32'h1234_5678);
         if (c == 3) begin
            cache_ready = 1; cache_rdata = 32'hDEAD_BEEF;
         end
         tick();
      end
      cache_ready = 0;
      check("t1_done",        32'(req0_done), 1);
      check("t1_err",         32'(req0_err), 0);
      check("t1_rdata",       req0_rdata, 0);
      check("t1_other_done",  32'(req1_done), 0);
      check("t1_valid_done",  32'(cache_valid), 0);
      check("t1_busy_done",   32'(busy), 1);
      tick();
      check("t1_done_pulse",  32'(req0_done), 0);
      check("t1_busy_idle",   32'(busy), 0);

      // Port 1 read, cache answers in the first BUSY cycle.
      req1_valid = 1; req1_rw = 0; req1_addr = 32'h8000_0004;
      #1;
      check("t2_req1_ready", 32'(req1_ready), 1);
      tick();
      req1_valid = 0;
      check("t2_cache_addr", cache_addr, 32'h8000_0004);
      check("t2_cache_rw",   32'(cache_rw), 0);
      cache_ready = 1; cache_rdata = 32'hAABB_CCDD;
      tick();
      cache_ready = 0; cache_rdata = '0;
      check("t2_req1_done",  32'(req1_done), 1);
      check("t2_req1_rdata", req1_rdata, 32'hAABB_CCDD);
      check("t2_req0_done",  32'(req0_done), 0);
      check("t2_req0_rdata", req0_rdata, 0);
      tick();
      check("t2_rdata_idle", req1_rdata, 0);

      // Round robin after reset: both ports valid for four transactions.
      rst_n = 0;
      #2;
      rst_n = 1;
      tick();
      req0_valid = 1; req0_rw = 0; req0_addr = 32'h0000_0100;
      req1_valid = 1; req1_rw = 0; req1_addr = 32'h0000_0200;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("rr_ready0", 32'(req0_ready), (i % 2 == 0) ? 1 : 0);
         check("rr_ready1", 32'(req1_ready), (i % 2 == 1) ? 1 : 0);
         tick();
         check("rr_addr", cache_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
         cache_ready = 1; cache_rdata = 32'h5000_0000 + 32'(i);
         tick();
         cache_ready = 0;
         check("rr_done0", 32'(req0_done), (i % 2 == 0) ? 1 : 0);
         check("rr_done1", 32'(req1_done), (i % 2 == 1) ? 1 : 0);
         check("rr_rdata", (i % 2 == 0) ? req0_rdata : req1_rdata, 32'h5000_0000 + 32'(i));
         check("rr_no_accept_done", 32'({req0_ready, req1_ready}), 0);
         tick();
         #1;
      end
      req0_valid = 0; req1_valid = 0;
      tick();

      // Watchdog expiry: cache_valid high for exactly 8 cycles.
      req0_valid = 1; req0_rw = 0; req0_addr = 32'h0000_0300;
      tick();
      req0_valid = 0;
      cache_rdata = 32'h7777_7777;
      for (int c = 0; c < 8; c++) begin
         check("wd_valid_high", 32'(cache_valid), 1);
         tick();
      end
      check("wd_valid_low", 32'(cache_valid), 0);
      check("wd_done",      32'(req0_done), 1);
      check("wd_err",       32'(req0_err), 1);
      check("wd_rdata",     req0_rdata, 0);
      tick();
      check("wd_idle_busy", 32'(busy), 0);
      check("wd_err_clear", 32'(req0_err), 0);

      // cache_ready in the final watchdog cycle wins.
      req0_valid = 1; req0_rw = 0; req0_addr = 32'h0000_0400;
      tick();
      req0_valid = 0;
      for (int c = 0; c < 7; c++) tick();
      check("wd8_still_valid", 32'(cache_valid), 1);
      cache_ready = 1; cache_rdata = 32'hCAFE_0001;
      tick();
      cache_ready = 0;
      check("wd8_done",  32'(req0_done), 1);
      check("wd8_err",   32'(req0_err), 0);
      check("wd8_rdata", req0_rdata, 32'hCAFE_0001);
      tick();

      // Reset asserted mid-BUSY drops the transaction.
      req1_valid = 1; req1_rw = 1; req1_addr = 32'h0000_0500; req1_wdata = 32'h1111_2222;
      tick();
      req1_valid = 0;
      tick();
      #2;
      rst_n = 0;
      #1;
      check("rb_cache_valid", 32'(cache_valid), 0);
      check("rb_cache_addr",  cache_addr, 0);
      check("rb_cache_wdata", cache_wdata, 0);
      check("rb_busy",        32'(busy), 0);
      req0_valid = 1; req1_valid = 1;
      #1;
      check("rb_ready_in_rst", 32'({req0_ready, req1_ready}), 0);
      #2;
      rst_n = 1;
      #1;
      check("rb_tie_ready0", 32'(req0_ready), 1);
      check("rb_tie_ready1", 32'(req1_ready), 0);
      req0_valid = 0; req1_valid = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rb_no_done", 32'({req0_done, req1_done}), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
